// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: BCD digit/score types,
// the game state encoding and the score ceiling.
`timescale 1ns/1ps
package score_pkg;

    typedef logic [3:0]       bcd_digit_t;
    typedef logic [2:0][3:0]  score_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } score_state_t;

    localparam score_t SCORE_MAX_BCD = 12'h999;

    // Awards above 9 are not valid BCD; treat them as the largest digit.
    function automatic bcd_digit_t clamp_bcd(input logic [3:0] value);
        return (value > 4'd9) ? 4'd9 : value;
    endfunction

endpackage

// File: rtl/score_keeper_bcd.sv
// Single-digit BCD adder with carry in/out; the score keeper chains three of
// these units -> tens -> hundreds so the whole add settles in one clock.
`timescale 1ns/1ps
module bcd_digit_add
    import score_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       carry_i,
    output bcd_digit_t sum_o,
    output logic       carry_o
);

    logic [4:0] raw;

    // Binary add, then fold anything above 9 back into a decimal digit.
    always_comb begin
        raw     = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, carry_i};
        carry_o = (raw > 5'd9);
        sum_o   = carry_o ? 4'(raw - 5'd10) : raw[3:0];
    end

endmodule

// File: rtl/score_keeper.sv
// Score keeper: BCD score, lives and post-hit invulnerability for the game.
// Optional feature macro: SCORE_BONUS_LIFE_EN -- an award that raises the
// hundreds digit grants one extra life (saturating at MAX_LIVES).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | after reset; hits ignored, waiting for newGame
// PLAYING   | hits score points and cost lives
// INVULN    | after a hit; player hits ignored, counts frames back to PLAYING
// GAME_OVER | lives exhausted; hits ignored until newGame
`timescale 1ns/1ps
module score_keeper
    import score_pkg::*;
#(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 7,
    parameter int INVULN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        newGame,
    input  logic        alienHit,
    input  logic [3:0]  points,
    input  logic        playerHit,
    output score_t      score,
    output logic [2:0]  lives,
    output logic        gameOver,
    output logic        invulnerable,
    output logic        scoreChanged
);

    localparam int FW = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;
    localparam logic [FW-1:0] FRAMES_LOAD = FW'(INVULN_FRAMES);
    localparam logic [2:0]    LIVES_INIT  = 3'(INIT_LIVES);
    localparam logic [2:0]    LIVES_MAX   = 3'(MAX_LIVES);
    // A zero-length invulnerability window means a hit goes straight back to play.
    localparam score_state_t  HIT_STATE   = (INVULN_FRAMES == 0) ? PLAYING : INVULN;

    score_state_t  state_q, state_d;
    score_t        score_q, score_d;
    logic [2:0]    lives_q, lives_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          game_over_q, game_over_d;
    logic          invuln_q, invuln_d;
    logic          changed_q, changed_d;

    bcd_digit_t    pts;
    score_t        sum_raw;
    score_t        sum_sat;
    logic [2:0]    carry;
    logic          active;
    logic          add_en;
    logic          bonus_life;

    assign pts    = clamp_bcd(points);
    assign active = (state_q == PLAYING) || (state_q == INVULN);
    assign add_en = active && alienHit && (pts != 4'd0);

    bcd_digit_add u_units (
        .a_i     (score_q[0]),
        .b_i     (pts),
        .carry_i (1'b0),
        .sum_o   (sum_raw[0]),
        .carry_o (carry[0])
    );

    bcd_digit_add u_tens (
        .a_i     (score_q[1]),
        .b_i     (4'd0),
        .carry_i (carry[0]),
        .sum_o   (sum_raw[1]),
        .carry_o (carry[1])
    );

    bcd_digit_add u_hundreds (
        .a_i     (score_q[2]),
        .b_i     (4'd0),
        .carry_i (carry[1]),
        .sum_o   (sum_raw[2]),
        .carry_o (carry[2])
    );

    // A carry out of the hundreds digit means we passed 999; pin there.
    assign sum_sat = carry[2] ? SCORE_MAX_BCD : sum_raw;

`ifdef SCORE_BONUS_LIFE_EN
    assign bonus_life = add_en && (sum_sat[2] > score_q[2]);
`else
    assign bonus_life = 1'b0;
`endif

    // Next-state: game control, score add, lives and frame countdown.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        frame_d   = frame_q;
        changed_d = 1'b0;

        if (newGame) begin
            state_d   = PLAYING;
            score_d   = '0;
            lives_d   = LIVES_INIT;
            frame_d   = '0;
            changed_d = (score_q != '0);
        end else if (active) begin
            if (add_en) begin
                score_d   = sum_sat;
                changed_d = (sum_sat != score_q);
            end

            if ((state_q == INVULN) && startOfFrame) begin
                if (frame_q <= FW'(1)) begin
                    frame_d = '0;
                    state_d = PLAYING;
                end else begin
                    frame_d = frame_q - FW'(1);
                end
            end

            if ((state_q == PLAYING) && playerHit) begin
                if (bonus_life) begin
                    // Extra life and hit cancel out; the hit still starts invulnerability.
                    state_d = HIT_STATE;
                    frame_d = FRAMES_LOAD;
                end else if (lives_q > 3'd1) begin
                    lives_d = lives_q - 3'd1;
                    state_d = HIT_STATE;
                    frame_d = FRAMES_LOAD;
                end else begin
                    lives_d = '0;
                    state_d = GAME_OVER;
                end
            end else if (bonus_life && (lives_q < LIVES_MAX)) begin
                lives_d = lives_q + 3'd1;
            end
        end

        game_over_d = (state_d == GAME_OVER);
        invuln_d    = (state_d == INVULN);
    end

    // State and output registers, cleared asynchronously by resetN.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            score_q     <= '0;
            lives_q     <= LIVES_INIT;
            frame_q     <= '0;
            game_over_q <= 1'b0;
            invuln_q    <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
            frame_q     <= frame_d;
            game_over_q <= game_over_d;
            invuln_q    <= invuln_d;
            changed_q   <= changed_d;
        end
    end

    assign score        = score_q;
    assign lives        = lives_q;
    assign gameOver     = game_over_q;
    assign invulnerable = invuln_q;
    assign scoreChanged = changed_q;

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper (INVULN_FRAMES=2 so the invulnerability window is
// short). Expected output snapshots are queued as each stimulus cycle is
// driven and popped for comparison one clock later.
`timescale 1ns/1ps
module tb_score_keeper;

    localparam int INIT_LIVES    = 3;
    localparam int MAX_LIVES     = 7;
    localparam int INVULN_FRAMES = 2;
`ifdef SCORE_BONUS_LIFE_EN
    localparam bit BONUS = 1'b1;
`else
    localparam bit BONUS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetN = 1'b1;
    logic             startOfFrame = 1'b0;
    logic             newGame = 1'b0;
    logic             alienHit = 1'b0;
    logic [3:0]       points = 4'd0;
    logic             playerHit = 1'b0;
    logic [2:0][3:0]  score;
    logic [2:0]       lives;
    logic             gameOver;
    logic             invulnerable;
    logic             scoreChanged;

    typedef struct packed {
        logic [11:0] score;
        logic [2:0]  lives;
        logic        go;
        logic        inv;
        logic        chg;
    } exp_t;

    typedef struct packed {
        logic       ng;
        logic       ah;
        logic [3:0] pts;
        logic       ph;
        logic       sof;
    } stim_t;

    exp_t  exp_q[$];
    stim_t stim_q[$];
    int    vecs = 0;
    int    errs = 0;

    always #5 clk = ~clk;

    score_keeper #(
        .INIT_LIVES    (INIT_LIVES),
        .MAX_LIVES     (MAX_LIVES),
        .INVULN_FRAMES (INVULN_FRAMES)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .newGame      (newGame),
        .alienHit     (alienHit),
        .points       (points),
        .playerHit    (playerHit),
        .score        (score),
        .lives        (lives),
        .gameOver     (gameOver),
        .invulnerable (invulnerable),
        .scoreChanged (scoreChanged)
    );

    function automatic stim_t S(input logic ng, input logic ah, input logic [3:0] pts,
                                input logic ph, input logic sof);
        return '{ng: ng, ah: ah, pts: pts, ph: ph, sof: sof};
    endfunction

    function automatic exp_t X(input logic [11:0] s, input int l, input logic go,
                               input logic inv, input logic chg);
        return '{score: s, lives: 3'(l), go: go, inv: inv, chg: chg};
    endfunction

    function automatic exp_t observed();
        return {score, lives, gameOver, invulnerable, scoreChanged};
    endfunction

    // Queue one stimulus cycle together with the outputs it must produce.
    task automatic stage(input stim_t s, input exp_t x);
        stim_q.push_back(s);
        exp_q.push_back(x);
    endtask

    task automatic tick(input stim_t s);
        @(negedge clk);
        newGame = s.ng; alienHit = s.ah; points = s.pts; playerHit = s.ph; startOfFrame = s.sof;
        @(posedge clk);
        #1;
        newGame = 1'b0; alienHit = 1'b0; points = 4'd0; playerHit = 1'b0; startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        #1 resetN = 1'b0;
        exp_q.push_back(X(12'h000, 3, 0, 0, 0));
        #2;
        e = exp_q.pop_front(); o = observed(); vecs++;
        if (o !== e) begin
            errs++;
            $display("FAIL reset_async: got s=%h l=%0d go=%b inv=%b chg=%b exp s=%h l=%0d go=%b inv=%b chg=%b",
                     o.score, o.lives, o.go, o.inv, o.chg, e.score, e.lives, e.go, e.inv, e.chg);
        end
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(X(12'h000, 3, 0, 0, 0));
        e = exp_q.pop_front(); o = observed(); vecs++;
        if (o !== e) begin
            errs++;
            $display("FAIL reset_held: got s=%h l=%0d go=%b inv=%b chg=%b exp s=%h l=%0d go=%b inv=%b chg=%b",
                     o.score, o.lives, o.go, o.inv, o.chg, e.score, e.lives, e.go, e.inv, e.chg);
        end
        @(negedge clk) resetN = 1'b1;
    endtask

    task automatic test_add();
        exp_t e, o;
        int i = 0;
        stage(S(0, 1, 4'd5,  0, 0), X(12'h000, 3, 0, 0, 0));  // IDLE ignores hits
        stage(S(1, 0, 4'd0,  0, 0), X(12'h000, 3, 0, 0, 0));  // reload of 000: no pulse
        stage(S(0, 1, 4'd5,  0, 0), X(12'h005, 3, 0, 0, 1));
        stage(S(0, 0, 4'd0,  0, 0), X(12'h005, 3, 0, 0, 0));  // single pulse
        stage(S(0, 1, 4'd0,  0, 0), X(12'h005, 3, 0, 0, 0));  // zero award
        stage(S(0, 1, 4'd12, 0, 0), X(12'h014, 3, 0, 0, 1));  // 12 clamps to 9
        stage(S(1, 1, 4'd7,  1, 0), X(12'h000, 3, 0, 0, 1));  // newGame wins
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front(); o = observed(); vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL add[%0d]: got s=%h l=%0d go=%b inv=%b chg=%b exp s=%h l=%0d go=%b inv=%b chg=%b",
                         i, o.score, o.lives, o.go, o.inv, o.chg, e.score, e.lives, e.go, e.inv, e.chg);
            end
            i++;
        end
    endtask

    task automatic test_carry();
        exp_t e, o;
        int i = 0;
        tick(S(1, 0, 4'd0, 0, 0));
        for (int k = 0; k < 10; k++) tick(S(0, 1, 4'd9, 0, 0));   // 090
        stage(S(0, 1, 4'd8, 0, 0), X(12'h098, 3, 0, 0, 1));
        stage(S(0, 1, 4'd7, 0, 0), X(12'h105, BONUS ? 4 : 3, 0, 0, 1));
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front(); o = observed(); vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL carry[%0d]: got s=%h l=%0d go=%b inv=%b chg=%b exp s=%h l=%0d go=%b inv=%b chg=%b",
                         i, o.score, o.lives, o.go, o.inv, o.chg, e.score, e.lives, e.go, e.inv, e.chg);
            end
            i++;
        end
    endtask

    task automatic test_saturate();
        exp_t e, o;
        int i = 0;
        int l = BONUS ? 7 : 3;   // nine hundreds-digit rises on the way to 990
        stage(S(1, 0, 4'd0, 0, 0), X(12'h000, 3, 0, 0, 1));
        tick(stim_q.pop_front());
        e = exp_q.pop_front(); o = observed(); vecs++;
        if (o !== e) begin
            errs++;
            $display("FAIL sat_newgame: got s=%h l=%0d go=%b inv=%b chg=%b exp s=%h l=%0d go=%b inv=%b chg=%b",
                     o.score, o.lives, o.go, o.inv, o.chg, e.score, e.lives, e.go, e.inv, e.chg);
        end
        for (int k = 0; k < 110; k++) tick(S(0, 1, 4'd9, 0, 0));  // 990
        stage(S(0, 1, 4'd5, 0, 0), X(12'h995, l, 0, 0, 1));
        stage(S(0, 1, 4'd9, 0, 0), X(12'h999, l, 0, 0, 1));
        stage(S(0, 1, 4'd9, 0, 0), X(12'h999, l, 0, 0, 0));
        stage(S(0, 1, 4'd1, 0, 0), X(12'h999, l, 0, 0, 0));
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front(); o = observed(); vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL saturate[%0d]: got s=%h l=%0d go=%b inv=%b chg=%b exp s=%h l=%0d go=%b inv=%b chg=%b",
                         i, o.score, o.lives, o.go, o.inv, o.chg, e.score, e.lives, e.go, e.inv, e.chg);
            end
            i++;
        end
    endtask

    task automatic test_invuln();
        exp_t e, o;
        int i = 0;
        stage(S(1, 0, 4'd0, 0, 0), X(12'h000, 3, 0, 0, 1));
        stage(S(0, 0, 4'd0, 1, 0), X(12'h000, 2, 0, 1, 0));
        stage(S(0, 0, 4'd0, 1, 0), X(12'h000, 2, 0, 1, 0));  // hit ignored
        stage(S(0, 0, 4'd0, 0, 0), X(12'h000, 2, 0, 1, 0));
        stage(S(0, 0, 4'd0, 0, 1), X(12'h000, 2, 0, 1, 0));  // 2 -> 1
        stage(S(0, 1, 4'd3, 0, 0), X(12'h003, 2, 0, 1, 1));  // scoring still works
        stage(S(0, 0, 4'd0, 0, 1), X(12'h003, 2, 0, 0, 0));  // 1 -> 0, back to play
        stage(S(0, 0, 4'd0, 1, 0), X(12'h003, 1, 0, 1, 0));
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front(); o = observed(); vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL invuln[%0d]: got s=%h l=%0d go=%b inv=%b chg=%b exp s=%h l=%0d go=%b inv=%b chg=%b",
                         i, o.score, o.lives, o.go, o.inv, o.chg, e.score, e.lives, e.go, e.inv, e.chg);
            end
            i++;
        end
    endtask

    task automatic test_game_over();
        exp_t e, o;
        int i = 0;
        stage(S(0, 0, 4'd0, 0, 1), X(12'h003, 1, 0, 1, 0));
        stage(S(0, 0, 4'd0, 0, 1), X(12'h003, 1, 0, 0, 0));
        stage(S(0, 1, 4'd3, 1, 0), X(12'h006, 0, 1, 0, 1));  // both applied
        stage(S(0, 1, 4'd5, 0, 0), X(12'h006, 0, 1, 0, 0));  // ignored
        stage(S(0, 0, 4'd0, 1, 0), X(12'h006, 0, 1, 0, 0));
        stage(S(1, 0, 4'd0, 0, 0), X(12'h000, 3, 0, 0, 1));
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front(); o = observed(); vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL game_over[%0d]: got s=%h l=%0d go=%b inv=%b chg=%b exp s=%h l=%0d go=%b inv=%b chg=%b",
                         i, o.score, o.lives, o.go, o.inv, o.chg, e.score, e.lives, e.go, e.inv, e.chg);
            end
            i++;
        end
    endtask

    task automatic test_reset_mid_invuln();
        exp_t e, o;
        int i = 0;
        tick(S(1, 0, 4'd0, 0, 0));
        tick(S(0, 1, 4'd5, 0, 0));
        tick(S(0, 0, 4'd0, 1, 0));   // now in INVULN, lives 2, score 005
        @(negedge clk);
        #1 resetN = 1'b0;
        exp_q.push_back(X(12'h000, 3, 0, 0, 0));
        #1;                           // still before the next rising edge
        e = exp_q.pop_front(); o = observed(); vecs++;
        if (o !== e) begin
            errs++;
            $display("FAIL reset_mid_invuln: got s=%h l=%0d go=%b inv=%b chg=%b exp s=%h l=%0d go=%b inv=%b chg=%b",
                     o.score, o.lives, o.go, o.inv, o.chg, e.score, e.lives, e.go, e.inv, e.chg);
        end
        @(negedge clk) resetN = 1'b1;
        stage(S(0, 1, 4'd5, 1, 0), X(12'h000, 3, 0, 0, 0));  // IDLE again
        stage(S(0, 0, 4'd0, 0, 1), X(12'h000, 3, 0, 0, 0));
        stage(S(1, 0, 4'd0, 0, 0), X(12'h000, 3, 0, 0, 0));
        stage(S(0, 1, 4'd4, 0, 0), X(12'h004, 3, 0, 0, 1));
        while (stim_q.size() > 0) begin
            tick(stim_q.pop_front());
            e = exp_q.pop_front(); o = observed(); vecs++;
            if (o !== e) begin
                errs++;
                $display("FAIL after_reset[%0d]: got s=%h l=%0d go=%b inv=%b chg=%b exp s=%h l=%0d go=%b inv=%b chg=%b",
                         i, o.score, o.lives, o.go, o.inv, o.chg, e.score, e.lives, e.go, e.inv, e.chg);
            end
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_saturate();
        test_invuln();
        test_game_over();
        test_reset_mid_invuln();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter INIT_LIVES, default 3: lives loaded at reset and at new game, range 1..MAX_LIVES.
REQ-002 SHALL have parameter MAX_LIVES, default 7: lives ceiling; fits the 3-bit lives output.
REQ-003 SHALL have parameter INVULN_FRAMES, default 60: frames of invulnerability after a player hit.
REQ-004 SHALL have port clk, input, 1 bit: system clock.
REQ-005 SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port startOfFrame, input, 1 bit: one-clock pulse per video frame.
REQ-007 SHALL have port newGame, input, 1 bit: one-clock pulse that starts a game.
REQ-008 SHALL have port alienHit, input, 1 bit: one-clock pulse that awards points.
REQ-009 SHALL have port points, input, 4 bits: BCD award, sampled with alienHit.
REQ-010 SHALL have port playerHit, input, 1 bit: one-clock pulse when the player is struck.
REQ-011 SHALL have port score, output, [2:0][3:0]: BCD digits, where score[0] is units and score[2] is hundreds; feeds the digit-bitmap drawers.
REQ-012 SHALL have port lives, output, 3 bits: remaining lives.
REQ-013 SHALL have port gameOver, output, 1 bit: high while in GAME_OVER.
REQ-014 SHALL have port invulnerable, output, 1 bit: high while in INVULN, for player blink.
REQ-015 SHALL have port scoreChanged, output, 1 bit: one-clock pulse when score changes.

Function
REQ-016 SHALL implement states IDLE, PLAYING, INVULN and GAME_OVER; every output SHALL be registered, with latency of 1 clock from the event.
REQ-017 newGame SHALL, in any state, load score=000, lives=INIT_LIVES, state=PLAYING and a cleared frame counter; it SHALL take priority over same-cycle alienHit and playerHit.
REQ-018 In IDLE and GAME_OVER, alienHit and playerHit SHALL be ignored.
REQ-019 alienHit in PLAYING or INVULN SHALL add points to the score as a BCD add with ripple carry units->tens->hundreds, completed in one clock.
REQ-020 A points value of 0 SHALL leave the score unchanged with no scoreChanged pulse; points values 10..15 SHALL be clamped to 9.
REQ-021 The score SHALL saturate at 999, with no wrap to 000.
REQ-022 playerHit in PLAYING with lives>1 SHALL decrement lives and enter INVULN with the frame counter loaded to INVULN_FRAMES.
REQ-023 When INVULN_FRAMES=0, playerHit in PLAYING SHALL return the block directly to PLAYING.
REQ-024 playerHit in PLAYING with lives==1 SHALL set lives=0 and enter GAME_OVER.
REQ-025 playerHit in INVULN SHALL be ignored.
REQ-026 In INVULN the frame counter SHALL decrement on each startOfFrame, and the block SHALL enter PLAYING on the startOfFrame that takes the counter to 0.
REQ-027 Same-cycle alienHit and playerHit SHALL both be applied, including the cycle that enters GAME_OVER.
REQ-028 scoreChanged SHALL pulse for exactly one clock, in the same cycle the new score value appears.
REQ-029 scoreChanged SHALL NOT pulse for a reload of a score that was already 000, nor for an add that saturates from 999.

Reset
REQ-030 resetN low SHALL asynchronously force state=IDLE, score=000, lives=INIT_LIVES, frame counter=0, and gameOver, invulnerable and scoreChanged to 0.
REQ-031 Reset mid-game, including mid-INVULN, SHALL discard all progress and wait for newGame.

Configuration
REQ-032 With SCORE_BONUS_LIFE_EN defined, an alienHit that raises the hundreds digit SHALL add one life, saturating at MAX_LIVES.
REQ-033 With SCORE_BONUS_LIFE_EN defined, a bonus life and a same-cycle playerHit SHALL net to lives unchanged with INVULN entered; this is not GAME_OVER, even when lives was 1.
REQ-034 With SCORE_BONUS_LIFE_EN defined, a saturating add that clamps at 999 SHALL still grant the bonus if the hundreds digit rose.
REQ-035 Without SCORE_BONUS_LIFE_EN, lives SHALL only decrease, and no bonus logic SHALL be synthesized.

Structure
REQ-036 Package score_pkg SHALL hold bcd_digit_t (4 bits), score_t ([2:0][3:0]), the state enum score_state_t and the constant SCORE_MAX_BCD (12'h999).
REQ-037 Sub-module bcd_digit_add SHALL be combinational: 4-bit digit a, 4-bit digit b and carry-in in; 4-bit digit sum and carry-out out; instanced once per digit.

Verification
REQ-038 Reset, then newGame, then alienHit with points=5 -> score 005 one clock later and a single scoreChanged pulse.
REQ-039 Score 098, alienHit with points=7 -> score 105 (carry into hundreds); with SCORE_BONUS_LIFE_EN, lives 3->4.
REQ-040 Score 995, alienHit with points=9 -> score 999; a further alienHit -> 999 with no scoreChanged pulse.
REQ-041 INIT_LIVES=3, INVULN_FRAMES=2: playerHit -> lives 2 and invulnerable=1; playerHit again -> ignored; two startOfFrame pulses -> invulnerable=0.
REQ-042 lives=1, playerHit together with alienHit points=3 -> gameOver=1, lives 0, score +3; a following newGame -> score 000, lives 3, gameOver=0.
REQ-043 resetN asserted mid-INVULN -> all outputs at reset values immediately, without waiting for a clock edge.
